fsm_experiment_seq: RTL

- Parametrised successor of the single-channel experiment sequencer.
- Sequence: wait for start, then wait for the function-generator edge, then delay.
- Then fires N staggered, maskable detonation pulses, waits for the wire-break edge with a timeout, delays, and drives the detector trigger until detector_ready or timeout.
- Adds input synchronisers, abort, fault reporting and status outputs.
- Sits between the front-panel/host control inputs and the detonator/detector drive lines.

---
 rtl/fsm_experiment_seq.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fsm_experiment_seq.sv
// Experiment sequencer: arm on start, wait for the function-generator edge,
// fire N staggered maskable detonation pulses, wait for the wire break,
// then drive the detector trigger until the detector reports ready.
// Every interval is counted in clock cycles by one shared counter.
module fsm_experiment_seq #(
  parameter int          N_CHANNELS   = 4,
  parameter int          CNT_W        = 32,
  parameter int unsigned FG_DELAY     = 400000,
  parameter int unsigned DET_WIDTH    = 50,
  parameter int unsigned CH_STAGGER   = 0,
  parameter int unsigned WIRE_TIMEOUT = 1000000,
  parameter int unsigned TRIG_DELAY   = 0,
  parameter int unsigned DET_TIMEOUT  = 500
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start_signal,
  input  logic                  fg_signal,
  input  logic                  wire_signal,
  input  logic                  detector_ready,
  input  logic [N_CHANNELS-1:0] channel_mask,
  input  logic                  abort,
  input  logic                  clear_fault,
  output logic [N_CHANNELS-1:0] detonation_signal,
  output logic                  output_trigger,
  output logic                  busy,
  output logic                  done,
  output logic                  det_timeout,
  output logic [1:0]            fault_code
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARMED,
    S_FG_WAIT,
    S_DETONATE,
    S_WIRE_WAIT,
    S_TRIG_DELAY,
    S_TRIGGER,
    S_FINISHED,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE  = 2'd0,
    FAULT_ABORT = 2'd1,
    FAULT_WIRE  = 2'd2,
    FAULT_MASK  = 2'd3
  } fault_t;

  // Total DETONATE length: last channel's start offset plus one pulse width.
  localparam int unsigned DET_LEN = (N_CHANNELS - 1) * CH_STAGGER + DET_WIDTH;

  // Limits widened by one bit so they compare directly against cnt + 1.
  localparam logic [CNT_W:0] FG_LIM   = (CNT_W+1)'(FG_DELAY);
  localparam logic [CNT_W:0] DET_LIM  = (CNT_W+1)'(DET_LEN);
  localparam logic [CNT_W:0] PULSE_W  = (CNT_W+1)'(DET_WIDTH);
  localparam logic [CNT_W:0] WIRE_LIM = (CNT_W+1)'(WIRE_TIMEOUT);
  localparam logic [CNT_W:0] TRIG_LIM = (CNT_W+1)'(TRIG_DELAY);
  localparam logic [CNT_W:0] DTO_LIM  = (CNT_W+1)'(DET_TIMEOUT);
  localparam logic [CNT_W:0] CNT_ONE  = (CNT_W+1)'(1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W:0]          cnt_inc;
  logic [N_CHANNELS-1:0]   mask_q;

  logic fg_s1, fg_s2, fg_d;
  logic wire_s1, wire_s2, wire_d;
  logic rdy_s1, rdy_s2;
  logic fg_edge, wire_edge;

  // Channel k is on while mask[k] and k*CH_STAGGER <= t < k*CH_STAGGER + DET_WIDTH.
  function automatic logic [N_CHANNELS-1:0] chan_on(
    input logic [N_CHANNELS-1:0] m,
    input logic [CNT_W:0]        t
  );
    logic [CNT_W:0] lo;
    chan_on = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      lo = (CNT_W+1)'(k * CH_STAGGER);
      chan_on[k] = m[k] && (t >= lo) && (t < lo + PULSE_W);
    end
  endfunction

  // The counter's next value, one bit wider so "count + 1 >= limit" never wraps.
  assign cnt_inc = {1'b0, cnt} + CNT_ONE;

  assign fg_edge   = fg_s2 & ~fg_d;
  assign wire_edge = wire_s2 & ~wire_d;
  assign busy      = (state != S_IDLE) && (state != S_FAULT);

  // Two-flop synchronisers for the asynchronous pins plus edge-detect delay flops.
  // NOTE: synchroniser flops are reset too, so no stale edge is seen right after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fg_s1   <= 1'b0;
      fg_s2   <= 1'b0;
      fg_d    <= 1'b0;
      wire_s1 <= 1'b0;
      wire_s2 <= 1'b0;
      wire_d  <= 1'b0;
      rdy_s1  <= 1'b0;
      rdy_s2  <= 1'b0;
    end else begin
      fg_s1   <= fg_signal;
      fg_s2   <= fg_s1;
      fg_d    <= fg_s2;
      wire_s1 <= wire_signal;
      wire_s2 <= wire_s1;
      wire_d  <= wire_s2;
      rdy_s1  <= detector_ready;
      rdy_s2  <= rdy_s1;
    end
  end

  // Sequencer FSM with registered outputs; abort overrides every other transition.
  // NOTE: all state and outputs use non-blocking assignments so every branch sees
  // the pre-edge values of cnt, state and mask_q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      cnt               <= '0;
      mask_q            <= '0;
      detonation_signal <= '0;
      output_trigger    <= 1'b0;
      done              <= 1'b0;
      det_timeout       <= 1'b0;
      fault_code        <= FAULT_NONE;
    end else begin
      done <= 1'b0;
      if (abort && busy) begin
        state             <= S_FAULT;
        cnt               <= '0;
        detonation_signal <= '0;
        output_trigger    <= 1'b0;
        fault_code        <= FAULT_ABORT;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_signal) begin
              state       <= S_ARMED;
              mask_q      <= channel_mask;
              det_timeout <= 1'b0;
              cnt         <= '0;
            end
          end

          S_ARMED: begin
            if (fg_edge) begin
              state <= S_FG_WAIT;
              cnt   <= '0;
            end
          end

          S_FG_WAIT: begin
            if (cnt_inc >= FG_LIM) begin
              cnt <= '0;
              if (mask_q == '0) begin
                state      <= S_FAULT;
                fault_code <= FAULT_MASK;
              end else begin
                state             <= S_DETONATE;
                detonation_signal <= chan_on(mask_q, '0);
              end
            end else begin
              cnt <= cnt_inc[CNT_W-1:0];
            end
          end

          S_DETONATE: begin
            if (cnt_inc >= DET_LIM) begin
              state             <= S_WIRE_WAIT;
              cnt               <= '0;
              detonation_signal <= '0;
            end else begin
              cnt               <= cnt_inc[CNT_W-1:0];
              detonation_signal <= chan_on(mask_q, cnt_inc);
            end
          end

          S_WIRE_WAIT: begin
            if (wire_edge) begin
              cnt <= '0;
              if (TRIG_DELAY == 0) begin
                state          <= S_TRIGGER;
                output_trigger <= 1'b1;
              end else begin
                state <= S_TRIG_DELAY;
              end
            end else if (cnt_inc >= WIRE_LIM) begin
              state      <= S_FAULT;
              cnt        <= '0;
              fault_code <= FAULT_WIRE;
            end else begin
              cnt <= cnt_inc[CNT_W-1:0];
            end
          end

          S_TRIG_DELAY: begin
            if (cnt_inc >= TRIG_LIM) begin
              state          <= S_TRIGGER;
              cnt            <= '0;
              output_trigger <= 1'b1;
            end else begin
              cnt <= cnt_inc[CNT_W-1:0];
            end
          end

          S_TRIGGER: begin
            if (rdy_s2) begin
              state          <= S_FINISHED;
              cnt            <= '0;
              output_trigger <= 1'b0;
              done           <= 1'b1;
            end else if (cnt_inc >= DTO_LIM) begin
              state          <= S_FINISHED;
              cnt            <= '0;
              output_trigger <= 1'b0;
              done           <= 1'b1;
              det_timeout    <= 1'b1;
            end else begin
              cnt <= cnt_inc[CNT_W-1:0];
            end
          end

          S_FINISHED: begin
            state <= S_IDLE;
          end

          S_FAULT: begin
            detonation_signal <= '0;
            output_trigger    <= 1'b0;
            if (clear_fault) begin
              state      <= S_IDLE;
              fault_code <= FAULT_NONE;
            end
          end

          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
